// File: rtl/hash_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hash_arbiter: round-robin sharing of one hash_block among NREQ requesters. |
// | Optional macro HASH_ARB_TIMEOUT_EN builds a WAIT-state watchdog.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hash_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_index,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic [159:0]      digest,
  output logic              busy,
  output logic              h_int,
  output logic [3:0]        h_index,
  input  logic              h_done,
  input  logic [159:0]      hh,
  output logic              hash_rst
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_ack;
  logic            r_err;
  logic            r_busy;
  logic            r_h_int;
  logic            r_hash_rst;
  logic [3:0]      r_h_index;
  logic [159:0]    r_digest;

`ifdef HASH_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] r_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  // Two candidates: lowest requester above the pointer, and lowest overall (the wrap case).
  logic            w_any_hi;
  logic            w_any;
  logic [PW-1:0]   w_sel_hi;
  logic [PW-1:0]   w_sel_lo;
  logic [3:0]      w_idx_hi;
  logic [3:0]      w_idx_lo;
  logic [PW-1:0]   w_sel;
  logic [3:0]      w_sel_idx;
  logic [NREQ-1:0] w_sel_oh;

  always_comb begin
    w_any_hi = 1'b0;
    w_any    = 1'b0;
    w_sel_hi = '0;
    w_sel_lo = '0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (PW'(i) > r_ptr)) begin
        w_any_hi = 1'b1;
        w_sel_hi = PW'(i);
        w_idx_hi = req_index[4*i +: 4];
      end
      if (req[i]) begin
        w_any    = 1'b1;
        w_sel_lo = PW'(i);
        w_idx_lo = req_index[4*i +: 4];
      end
    end
    w_sel     = w_any_hi ? w_sel_hi : w_sel_lo;
    w_sel_idx = w_any_hi ? w_idx_hi : w_idx_lo;
    w_sel_oh  = NREQ'(1) << w_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= PW'(NREQ - 1);
      r_gnt      <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_h_int    <= 1'b0;
      r_hash_rst <= 1'b0;
      r_h_index  <= '0;
      r_digest   <= '0;
`ifdef HASH_ARB_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt     <= w_sel_oh;
            r_busy    <= 1'b1;
            r_h_int   <= 1'b1;
            r_h_index <= w_sel_idx;
            r_ptr     <= w_sel;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_h_int <= 1'b0;
`ifdef HASH_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A completion arriving on the timeout edge takes precedence over the abort.
          if (h_done) begin
            r_digest <= hh;
            r_ack    <= r_gnt;
            r_err    <= 1'b0;
            r_state  <= S_RESP;
          end
`ifdef HASH_ARB_TIMEOUT_EN
          else if (r_cnt == LP_CNT_LAST) begin
            r_hash_rst <= 1'b1;
            r_ack      <= r_gnt;
            r_err      <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end
        S_RESP: begin
          r_ack      <= '0;
          r_gnt      <= '0;
          r_busy     <= 1'b0;
          r_err      <= 1'b0;
          r_hash_rst <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign ack      = r_ack;
  assign err      = r_err;
  assign digest   = r_digest;
  assign busy     = r_busy;
  assign h_int    = r_h_int;
  assign h_index  = r_h_index;
  assign hash_rst = r_hash_rst;

endmodule
`default_nettype wire

// File: tb/tb_hash_arbiter.sv
`default_nettype none
// Testbench for hash_arbiter: directed steps with randomized data, checked against a
// round-robin reference model.
module tb_hash_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;
`ifdef HASH_ARB_TIMEOUT_EN
  localparam int LONG_LAT = TIMEOUT - 2;
`else
  localparam int LONG_LAT = 28;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_index;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic [159:0]      digest;
  logic              busy;
  logic              h_int;
  logic [3:0]        h_index;
  logic              h_done;
  logic [159:0]      hh;
  logic              hash_rst;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int           m_last   = NREQ - 1;
  logic [159:0] m_digest = '0;

  hash_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_index(req_index),
    .gnt(gnt), .ack(ack), .err(err), .digest(digest), .busy(busy),
    .h_int(h_int), .h_index(h_index), .h_done(h_done), .hh(hh),
    .hash_rst(hash_rst)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int m_pick(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (m_last + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [159:0] rand160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Grant the request currently on req, complete after lat WAIT cycles.
  task automatic run_job(input int lat, input bit drop_req, input bit scramble,
                         input logic [159:0] d);
    int              g;
    logic [NREQ-1:0] oh;
    logic [3:0]      idx;
    g = m_pick(req);
    if (g < 0) g = 0;
    oh = '0;
    oh[g] = 1'b1;
    idx = req_index[4*g +: 4];
    tick();
    check("grant", {gnt, busy, h_int, h_index, ack}, {oh, 1'b1, 1'b1, idx, {NREQ{1'b0}}});
    m_last = g;
    if (drop_req) req[g] = 1'b0;
    tick();
    check("issue", {gnt, busy, h_int}, {oh, 1'b1, 1'b0});
    for (int i = 0; i < lat; i++) begin
      if (scramble) req_index = 8'($urandom());
      tick();
      check("wait", {ack, h_index, hash_rst, err}, {{NREQ{1'b0}}, idx, 1'b0, 1'b0});
    end
    hh = d;
    h_done = 1'b1;
    tick();
    h_done = 1'b0;
    hh = rand160();
    check("ack", {ack, err, hash_rst, gnt}, {oh, 1'b0, 1'b0, oh});
    check("digest", digest, d);
    m_digest = d;
    tick();
    check("resp", {gnt, ack, busy, h_int}, '0);
  endtask

`ifdef HASH_ARB_TIMEOUT_EN
  task automatic run_timeout(input bit tie, input logic [159:0] d);
    int              g;
    logic [NREQ-1:0] oh;
    g = m_pick(req);
    if (g < 0) g = 0;
    oh = '0;
    oh[g] = 1'b1;
    tick();
    check("to_grant", {gnt, h_int}, {oh, 1'b1});
    m_last = g;
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      check("to_wait", {ack, hash_rst}, '0);
    end
    if (tie) begin
      hh = d;
      h_done = 1'b1;
    end
    tick();
    h_done = 1'b0;
    if (tie) begin
      check("tie_ack", {ack, err, hash_rst}, {oh, 1'b0, 1'b0});
      check("tie_digest", digest, d);
      m_digest = d;
    end else begin
      check("to_ack", {ack, err, hash_rst}, {oh, 1'b1, 1'b1});
      check("to_digest", digest, m_digest);
    end
    tick();
    check("to_resp", {gnt, ack, busy, hash_rst}, '0);
  endtask
`endif

  initial begin
    logic [159:0] pat;
    rst = 1'b1;
    req = '0;
    req_index = '0;
    h_done = 1'b0;
    hh = '0;
    tick();
    tick();
    check("reset_outs", {gnt, ack, err, busy, h_int, h_index, hash_rst}, '0);
    check("reset_digest", digest, '0);
    rst = 1'b0;
    tick();
    tick();
    check("idle_noreq", {gnt, busy, h_int}, '0);

    // single request, index 5, A5 pattern
    pat = {20{8'hA5}};
    req = 2'b01;
    req_index = 8'h35;
    run_job(LONG_LAT, 1'b0, 1'b0, pat);
    req = '0;
    tick();
    check("idle_after", {gnt, busy}, '0);

    // round robin with both held, index scrambled during WAIT
    req = 2'b11;
    req_index = 8'($urandom());
    for (int j = 0; j < 4; j++) run_job(int'($urandom_range(0, 6)), 1'b0, 1'b1, rand160());

    // random request mixes, some dropped after grant
    for (int j = 0; j < 8; j++) begin
      req = 2'($urandom_range(1, 3));
      req_index = 8'($urandom());
      run_job(int'($urandom_range(0, 8)), 1'($urandom()), 1'($urandom()), rand160());
    end

    // mid-job reset
    req = 2'b11;
    req_index = 8'($urandom());
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = '0;
    m_last = NREQ - 1;
    m_digest = '0;
    check("midrst_outs", {gnt, ack, err, busy, h_int, h_index, hash_rst}, '0);
    check("midrst_digest", digest, '0);
    hh = rand160();
    h_done = 1'b1;
    tick();
    h_done = 1'b0;
    check("midrst_done_ignored", {gnt, ack, busy}, '0);
    tick();
    check("midrst_digest_kept", digest, '0);

    // after reset requester 0 has priority again
    req = 2'b11;
    req_index = 8'($urandom());
    run_job(2, 1'b0, 1'b0, rand160());
    run_job(1, 1'b0, 1'b0, rand160());

`ifdef HASH_ARB_TIMEOUT_EN
    req = 2'b01;
    run_timeout(1'b0, rand160());
    req = 2'b10;
    run_timeout(1'b1, rand160());
`endif

    req = '0;
    tick();
    check("final_idle", {gnt, ack, busy, hash_rst}, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
